// File: rtl/memr_pkg.sv
// Shared types and default widths for the mem_responder bus-slave memory.
package memr_pkg;

    localparam int unsigned MEMR_ADDR_W = 8;
    localparam int unsigned MEMR_DATA_W = 8;
    localparam int unsigned MEMR_CNT_W  = 4;
    localparam int unsigned MEMR_WCNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_HOLD,
        ERR
    } memr_state_t;

endpackage

// File: rtl/memr_array.sv
// Storage array: one synchronous write port, one combinational read port, no reset.
module memr_array
    import memr_pkg::*;
#(
    parameter int unsigned ADDR_W = MEMR_ADDR_W,
    parameter int unsigned DATA_W = MEMR_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// Bus-slave memory on the rd/wrt/add/dat bus with fixed read latency and protocol-error detection.
// Optional write protection of addresses 0..PROT_TOP is enabled by defining MEMR_WPROT_EN.
module mem_responder
    import memr_pkg::*;
#(
    parameter int unsigned       ADDR_W   = MEMR_ADDR_W,
    parameter int unsigned       DATA_W   = MEMR_DATA_W,
    parameter int unsigned       READ_LAT = 2,
    parameter logic [ADDR_W-1:0] PROT_TOP = ADDR_W'(8'h0F)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd,
    input  logic                   wrt,
    input  logic [ADDR_W-1:0]      add,
    inout  wire  [DATA_W-1:0]      dat,
    output logic                   bus_err,
    output logic [MEMR_WCNT_W-1:0] wr_cnt,
    output logic                   busy
`ifdef MEMR_WPROT_EN
    ,
    output logic                   wr_viol
`endif
);

    localparam logic [MEMR_CNT_W-1:0] LAT_INIT = MEMR_CNT_W'(READ_LAT - 1);

    // Elaboration-time parameter sanity checks.
    if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_lat
        $error("mem_responder: READ_LAT must be within 1..15");
    end
    if (PROT_TOP == '1) begin : g_bad_prot
        $error("mem_responder: PROT_TOP must leave at least one writable address");
    end

    memr_state_t            state_q,   state_d;
    logic [ADDR_W-1:0]      addr_q,    addr_d;
    logic [MEMR_CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DATA_W-1:0]      rdata_q,   rdata_d;
    logic                   bus_err_q, bus_err_d;
    logic [MEMR_WCNT_W-1:0] wr_cnt_q,  wr_cnt_d;
    logic                   busy_q,    busy_d;
    logic                   viol_q,    viol_d;
    logic                   we_c;
    logic                   wr_ok_c;
    logic [DATA_W-1:0]      mem_rdata_c;

    // A write landing on a reset edge must not reach the array.
    memr_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .we      (we_c & rst),
        .waddr   (add),
        .wdata   (dat),
        .raddr   (addr_q),
        .rdata_c (mem_rdata_c)
    );

`ifdef MEMR_WPROT_EN
    assign wr_ok_c = (add > PROT_TOP);
`else
    assign wr_ok_c = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            wr_cnt_q  <= '0;
            busy_q    <= 1'b0;
            viol_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            wr_cnt_q  <= wr_cnt_d;
            busy_q    <= busy_d;
            viol_q    <= viol_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        wr_cnt_d  = wr_cnt_q;
        viol_d    = 1'b0;
        we_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd && wrt) begin
                    state_d   = ERR;
                    bus_err_d = 1'b1;
                end else if (wrt) begin
                    state_d = WR_HOLD;
                    if (wr_ok_c) begin
                        we_c     = 1'b1;
                        wr_cnt_d = wr_cnt_q + MEMR_WCNT_W'(1);
                    end else begin
                        viol_d = 1'b1;
                    end
                end else if (rd) begin
                    state_d = RD_WAIT;
                    addr_d  = add;
                    cnt_d   = LAT_INIT;
                end
            end
            RD_WAIT: begin
                if (wrt) begin
                    state_d   = ERR;
                    bus_err_d = 1'b1;
                end else if (!rd) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RD_DRIVE;
                    rdata_d = mem_rdata_c;
                end else begin
                    cnt_d = cnt_q - MEMR_CNT_W'(1);
                end
            end
            RD_DRIVE: begin
                if (wrt) begin
                    state_d   = ERR;
                    bus_err_d = 1'b1;
                end else if (!rd) begin
                    state_d = IDLE;
                end
            end
            WR_HOLD: begin
                if (rd) begin
                    state_d   = ERR;
                    bus_err_d = 1'b1;
                end else if (!wrt) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (!rd && !wrt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // The bus is only ever driven while the processor is still requesting the read.
    assign dat = (state_q == RD_DRIVE && rd) ? rdata_q : {DATA_W{1'bz}};

    assign bus_err = bus_err_q;
    assign wr_cnt  = wr_cnt_q;
    assign busy    = busy_q;

`ifdef MEMR_WPROT_EN
    assign wr_viol = viol_q;
`else
    logic unused_viol_c;
    assign unused_viol_c = viol_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed test-plan sequences plus randomized bus traffic vs. a transaction-level model.
module tb_mem_responder;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned LAT = 2;
    localparam logic [7:0] PTOP = 8'h0F;
`ifdef MEMR_WPROT_EN
    localparam int WRAP_EXP = 240;
`else
    localparam int WRAP_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rd;
    logic          wrt;
    logic [AW-1:0] add;
    logic [DW-1:0] tb_dat;
    wire  [DW-1:0] dat;
    logic          bus_err;
    logic [7:0]    wr_cnt;
    logic          busy;
    logic          tb_drv;
`ifdef MEMR_WPROT_EN
    logic          wr_viol;
`endif

    mem_responder #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .READ_LAT (LAT),
        .PROT_TOP (PTOP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd      (rd),
        .wrt     (wrt),
        .add     (add),
        .dat     (dat),
        .bus_err (bus_err),
        .wr_cnt  (wr_cnt),
        .busy    (busy)
`ifdef MEMR_WPROT_EN
        ,
        .wr_viol (wr_viol)
`endif
    );

    // Processor side drives the bus only for a clean write request.
    assign tb_drv = wrt && !rd;
    assign dat    = tb_drv ? tb_dat : {DW{1'bz}};

    for (genvar i = 0; i < DW; i++) begin : g_pd
        pulldown pd (dat[i]);
    end

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Released bus reads as all-zero through the pulldowns; stored data is always nonzero.
    function automatic logic [31:0] bus_free();
        return {31'd0, (dat == 8'h00)};
    endfunction

    // Transaction-level model: read age since request, write-hold flag, error mode.
    bit         m_valid = 1'b0;
    bit         m_err_flag, m_in_err, m_wr_hold, m_viol;
    int         m_rd_age;
    logic [7:0] m_rd_addr;
    int         m_wcnt;
    logic [7:0] mem_m [logic [7:0]];

    function automatic bit is_prot(input logic [7:0] a);
`ifdef MEMR_WPROT_EN
        return a <= PTOP;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin : model_cmp
        logic       r_s, w_s;
        logic [7:0] a_s, d_s;
        r_s = rd; w_s = wrt; a_s = add; d_s = tb_dat;
        if (!rst) begin
            m_valid = 1'b1; m_err_flag = 1'b0; m_in_err = 1'b0; m_wr_hold = 1'b0;
            m_rd_age = -1; m_wcnt = 0; m_viol = 1'b0;
        end else if (m_valid) begin
            m_viol = 1'b0;
            if (m_in_err) begin
                if (!r_s && !w_s) m_in_err = 1'b0;
            end else if (m_wr_hold) begin
                if (r_s) begin m_wr_hold = 1'b0; m_in_err = 1'b1; m_err_flag = 1'b1; end
                else if (!w_s) m_wr_hold = 1'b0;
            end else if (m_rd_age >= 0) begin
                if (w_s) begin m_rd_age = -1; m_in_err = 1'b1; m_err_flag = 1'b1; end
                else if (!r_s) m_rd_age = -1;
                else if (m_rd_age < int'(LAT)) m_rd_age++;
            end else if (r_s && w_s) begin
                m_in_err = 1'b1; m_err_flag = 1'b1;
            end else if (w_s) begin
                m_wr_hold = 1'b1;
                if (is_prot(a_s)) m_viol = 1'b1;
                else begin mem_m[a_s] = d_s; m_wcnt = (m_wcnt + 1) % 256; end
            end else if (r_s) begin
                m_rd_age = 0; m_rd_addr = a_s;
            end
        end
        #1;
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(m_in_err || m_wr_hold || m_rd_age >= 0));
            chk("bus_err", 32'(bus_err), 32'(m_err_flag));
            chk("wr_cnt", 32'(wr_cnt), 32'(m_wcnt));
`ifdef MEMR_WPROT_EN
            chk("wr_viol", 32'(wr_viol), 32'(m_viol));
`endif
            if (m_rd_age >= int'(LAT) && rd) begin
                if (mem_m.exists(m_rd_addr)) chk("rd_data", 32'(dat), 32'(mem_m[m_rd_addr]));
            end else if (!tb_drv) begin
                chk("dat_hiz", bus_free(), 32'd1);
            end
        end
    end

    // Apply one set of inputs at the falling edge; return just after the next rising edge.
    task automatic cyc(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        rd = r; wrt = w; add = a; tb_dat = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; rd = 1'b0; wrt = 1'b0; add = '0; tb_dat = '0;
        cyc(0, 0, 8'h00, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        chk("lit_rst_busy", 32'(busy), 32'd0);
        chk("lit_rst_err", 32'(bus_err), 32'd0);
        chk("lit_rst_wcnt", 32'(wr_cnt), 32'd0);
        rst = 1'b1;

        // Held write commits once; read returns after LAT edges.
        repeat (3) cyc(0, 1, 8'h20, 8'hA5);
        chk("lit_wcnt_one", 32'(wr_cnt), 32'd1);
        cyc(0, 0, 8'h20, 8'h00);
        cyc(1, 0, 8'h20, 8'h00);
        chk("lit_rd_n_hiz", bus_free(), 32'd1);
        cyc(1, 0, 8'h20, 8'h00);
        chk("lit_rd_n1_hiz", bus_free(), 32'd1);
        cyc(1, 0, 8'h20, 8'h00);
        chk("lit_rd_a5", 32'(dat), 32'hA5);
        cyc(0, 0, 8'h20, 8'h00);
        chk("lit_rd_release", bus_free(), 32'd1);
        chk("lit_rd_idle", 32'(busy), 32'd0);

        // Address change during the read is ignored; read aborted in wait phase.
        cyc(1, 0, 8'h20, 8'h00);
        cyc(1, 0, 8'h21, 8'h00);
        cyc(1, 0, 8'h21, 8'h00);
        chk("lit_rd_latched", 32'(dat), 32'hA5);
        cyc(0, 0, 8'h21, 8'h00);
        cyc(1, 0, 8'h21, 8'h00);
        cyc(0, 0, 8'h21, 8'h00);
        chk("lit_abort_idle", 32'(busy), 32'd0);

        // Simultaneous rd/wrt: sticky error until reset.
        cyc(1, 1, 8'h20, 8'h00);
        chk("lit_err_set", 32'(bus_err), 32'd1);
        cyc(1, 0, 8'h20, 8'h00);
        chk("lit_err_hold", 32'(busy), 32'd1);
        cyc(0, 1, 8'h20, 8'h77);
        cyc(0, 0, 8'h20, 8'h00);
        chk("lit_err_exit", 32'(busy), 32'd0);
        repeat (3) cyc(1, 0, 8'h20, 8'h00);
        chk("lit_err_rd", 32'(dat), 32'hA5);
        chk("lit_err_sticky", 32'(bus_err), 32'd1);
        cyc(0, 0, 8'h20, 8'h00);
        rst = 1'b0;
        cyc(0, 0, 8'h00, 8'h00);
        chk("lit_err_clr", 32'(bus_err), 32'd0);
        rst = 1'b1;

        // Fill every address, counter wraps, read everything back.
        for (int a = 0; a < 256; a++) begin
            cyc(0, 1, 8'(a), {7'(a), 1'b1});
            cyc(0, 0, 8'(a), 8'h00);
        end
        chk("lit_wcnt_wrap", 32'(wr_cnt), 32'(WRAP_EXP));
        for (int a = 0; a < 256; a++) begin
            repeat (LAT + 1) cyc(1, 0, 8'(a), 8'h00);
            if (a == 8'h20) chk("lit_fill_20", 32'(dat), 32'h41);
            cyc(0, 0, 8'(a), 8'h00);
        end

        // Reset while driving the bus.
        repeat (3) cyc(1, 0, 8'h40, 8'h00);
        rst = 1'b0;
        cyc(1, 0, 8'h40, 8'h00);
        chk("lit_rst_drv_hiz", bus_free(), 32'd1);
        chk("lit_rst_drv_busy", 32'(busy), 32'd0);
        chk("lit_rst_drv_wcnt", 32'(wr_cnt), 32'd0);
        rst = 1'b1;
        cyc(0, 0, 8'h40, 8'h00);
        repeat (3) cyc(1, 0, 8'h40, 8'h00);
        chk("lit_after_rst_rd", 32'(dat), 32'h81);
        cyc(0, 0, 8'h40, 8'h00);

`ifdef MEMR_WPROT_EN
        cyc(0, 1, 8'h05, 8'h33);
        chk("lit_prot_wcnt", 32'(wr_cnt), 32'd0);
        chk("lit_prot_viol", 32'(wr_viol), 32'd1);
        cyc(0, 0, 8'h05, 8'h00);
        chk("lit_prot_pulse", 32'(wr_viol), 32'd0);
        cyc(0, 1, 8'h10, 8'h5B);
        chk("lit_prot_ok", 32'(wr_cnt), 32'd1);
        cyc(0, 0, 8'h10, 8'h00);
        repeat (3) cyc(1, 0, 8'h10, 8'h00);
        chk("lit_prot_rd", 32'(dat), 32'h5B);
        cyc(0, 0, 8'h10, 8'h00);
`endif

        // Random traffic, including protocol violations and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic r, w;
            r = rd; w = wrt;
            if ($urandom_range(0, 3) == 0) r = !r;
            if ($urandom_range(0, 5) == 0) w = !w;
            rst = ($urandom_range(0, 99) != 0);
            cyc(r, w, 8'($urandom_range(0, 31)), 8'($urandom_range(1, 255)));
        end
        rst = 1'b1;
        cyc(0, 0, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
